// File: rtl/vga_fb_reader.sv
// Frame-buffer read scheduler: on each VGA frame start, issues AXI INCR read
// bursts covering the whole frame, throttled by free space in the downstream
// pixel FIFO (counting beats already requested but not yet returned).
//
// Handshake rules: an AR transfer happens on a SYSCLK edge where
// M_AXI_ARVALID && M_AXI_ARREADY; once ARVALID rises, ARVALID and ARADDR hold
// until that edge. An R beat counts only on an edge where
// M_AXI_RVALID && M_AXI_RREADY (this block only monitors the R channel).
module vga_fb_reader #(
   parameter logic [31:0] FB_BASE     = 32'h8000_0000,
   parameter int          H_ACT       = 640,
   parameter int          V_ACT       = 480,
   parameter int          BURST_LEN   = 16,
   parameter int          FIFO_DEPTH  = 1024,
   parameter int          FIFO_MARGIN = 16
) (
   input  logic        SYSCLK,
   input  logic        RST,
   input  logic        VGA_VS,
   input  logic [9:0]  FIFO_WR_CNT,
   output logic [31:0] M_AXI_ARADDR,
   output logic [7:0]  M_AXI_ARLEN,
   output logic [2:0]  M_AXI_ARSIZE,
   output logic [1:0]  M_AXI_ARBURST,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic        M_AXI_RVALID,
   input  logic        M_AXI_RREADY,
   input  logic        M_AXI_RLAST,
   input  logic [1:0]  M_AXI_RRESP,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        err_o,
   output logic [1:0]  dbg_state_o,
   output logic [10:0] dbg_outstanding_o,
   output logic        dbg_last_beat_o
);

   localparam int              TOTAL_BURSTS = (H_ACT * V_ACT) / BURST_LEN;
   localparam int              BC_W         = $clog2(TOTAL_BURSTS + 1);
   localparam logic [BC_W-1:0] LAST_BURST   = BC_W'(TOTAL_BURSTS);
   localparam logic [BC_W-1:0] BC_ONE       = BC_W'(1);
   localparam logic [10:0]     BEATS        = 11'(BURST_LEN);
   localparam logic [31:0]     ADDR_STEP    = 32'(4 * BURST_LEN);
   localparam logic [31:0]     BURST_WORDS  = 32'(BURST_LEN);
   localparam logic [31:0]     ROOM_LIMIT   = 32'(FIFO_DEPTH - FIFO_MARGIN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ADDR  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [10:0]     out_q, out_d;
   logic            abort_pend_q, abort_pend_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            vs_meta_q, vs_meta_d;
   logic            vs_sync_q, vs_sync_d;
   logic            vs_prev_q, vs_prev_d;

   logic frame_start;
   logic frame_abort;
   logic ar_hs;
   logic r_beat;
   logic fifo_room;

   // Fixed burst shape: BURST_LEN beats of 4 bytes, incrementing.
   assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_ARSIZE  = 3'b010;
   assign M_AXI_ARBURST = 2'b01;

   assign M_AXI_ARVALID = (state_q == ADDR);
   assign M_AXI_ARADDR  = addr_q;
   assign busy_o        = (state_q != IDLE);
   assign frame_done_o  = done_q;
   assign err_o         = err_q;

   assign dbg_state_o       = state_q;
   assign dbg_outstanding_o = out_q;
   assign dbg_last_beat_o   = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;

   assign frame_start = vs_sync_q && !vs_prev_q;
   assign frame_abort = !vs_sync_q && vs_prev_q;
   assign ar_hs       = M_AXI_ARVALID && M_AXI_ARREADY;
   assign r_beat      = M_AXI_RVALID && M_AXI_RREADY;
   // Requested-but-unreturned beats already own FIFO space.
   assign fifo_room   = ({22'd0, FIFO_WR_CNT} + {21'd0, out_q} + BURST_WORDS) <= ROOM_LIMIT;

   // Two-flop synchronizer on VGA_VS followed by an edge-detect flop.
   always_comb begin
      vs_meta_d = VGA_VS;
      vs_sync_d = vs_meta_q;
      vs_prev_d = vs_sync_q;
   end

   // Frame FSM: next state, burst address and burst count.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      burst_cnt_d  = burst_cnt_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            abort_pend_d = 1'b0;
            if (frame_start) begin
               addr_d      = FB_BASE;
               burst_cnt_d = '0;
               state_d     = CHECK;
            end
         end
         CHECK: begin
            if (frame_abort) begin
               state_d = DRAIN;
            end else if (fifo_room) begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            // An abort here must not break the pending handshake; remember it.
            if (frame_abort) begin
               abort_pend_d = 1'b1;
            end
            if (ar_hs) begin
               addr_d      = addr_q + ADDR_STEP;
               burst_cnt_d = burst_cnt_q + BC_ONE;
               if ((burst_cnt_q + BC_ONE) == LAST_BURST || abort_pend_q || frame_abort) begin
                  state_d      = DRAIN;
                  abort_pend_d = 1'b0;
               end else begin
                  state_d = CHECK;
               end
            end
         end
         DRAIN: begin
            abort_pend_d = 1'b0;
            if (out_q == 11'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outstanding-beat tracking and sticky error flag.
   always_comb begin
      out_d = out_q;
      err_d = err_q;
      if (ar_hs && r_beat) begin
         out_d = out_q + BEATS - 11'd1;
      end else if (ar_hs) begin
         out_d = out_q + BEATS;
      end else if (r_beat) begin
         // A beat nobody asked for is an error; the count stays pinned at 0.
         if (out_q == 11'd0) begin
            err_d = 1'b1;
         end else begin
            out_d = out_q - 11'd1;
         end
      end
      if (r_beat && (M_AXI_RRESP != 2'b00)) begin
         err_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         state_q      <= IDLE;
         addr_q       <= FB_BASE;
         burst_cnt_q  <= '0;
         out_q        <= 11'd0;
         abort_pend_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         vs_meta_q    <= 1'b1;
         vs_sync_q    <= 1'b1;
         vs_prev_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         burst_cnt_q  <= burst_cnt_d;
         out_q        <= out_d;
         abort_pend_q <= abort_pend_d;
         done_q       <= done_d;
         err_q        <= err_d;
         vs_meta_q    <= vs_meta_d;
         vs_sync_q    <= vs_sync_d;
         vs_prev_q    <= vs_prev_d;
      end
   end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: a reduced frame (64x40 pixels, 160 bursts) with an
// AXI read slave model returning beats 4 cycles after each accepted AR.
module tb_vga_fb_reader;

   localparam logic [31:0] FB_BASE     = 32'h8000_0000;
   localparam int          H_ACT       = 64;
   localparam int          V_ACT       = 40;
   localparam int          BURST_LEN   = 16;
   localparam int          FIFO_DEPTH  = 1024;
   localparam int          FIFO_MARGIN = 16;
   localparam int          TOTAL       = (H_ACT * V_ACT) / BURST_LEN;
   localparam int          LIMIT       = FIFO_DEPTH - FIFO_MARGIN;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        VGA_VS = 1'b1;
   logic [9:0]  FIFO_WR_CNT = '0;
   logic [31:0] M_AXI_ARADDR;
   logic [7:0]  M_AXI_ARLEN;
   logic [2:0]  M_AXI_ARSIZE;
   logic [1:0]  M_AXI_ARBURST;
   logic        M_AXI_ARVALID;
   logic        M_AXI_ARREADY = 1'b0;
   logic        M_AXI_RVALID = 1'b0;
   logic        M_AXI_RREADY = 1'b0;
   logic        M_AXI_RLAST = 1'b0;
   logic [1:0]  M_AXI_RRESP = 2'b00;
   logic        busy_o;
   logic        frame_done_o;
   logic        err_o;
   logic [1:0]  dbg_state_o;
   logic [10:0] dbg_outstanding_o;
   logic        dbg_last_beat_o;

   always #5 clk = ~clk;

   vga_fb_reader #(
      .FB_BASE(FB_BASE), .H_ACT(H_ACT), .V_ACT(V_ACT), .BURST_LEN(BURST_LEN),
      .FIFO_DEPTH(FIFO_DEPTH), .FIFO_MARGIN(FIFO_MARGIN)
   ) dut (
      .SYSCLK(clk), .RST(RST), .VGA_VS(VGA_VS), .FIFO_WR_CNT(FIFO_WR_CNT),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
      .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
      .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RRESP(M_AXI_RRESP),
      .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o),
      .dbg_state_o(dbg_state_o), .dbg_outstanding_o(dbg_outstanding_o),
      .dbg_last_beat_o(dbg_last_beat_o)
   );

   // ---------------- stimulus policy ----------------
   logic       rst_pol = 1'b1;
   logic       vs_pol = 1'b1;
   logic [9:0] fifo_pol = '0;
   int         ar_mode = 1;       // 0: ARREADY low, 1: high, 2: random
   bit         r_en = 1'b1;
   int         r_floor = 0;       // slave withholds beats while outstanding <= floor
   bit         r_stall_rand = 1'b0;
   bit         err_beat_pend = 1'b0;
   bit         force_beat = 1'b0;

   // ---------------- scoreboard / reference model ----------------
   logic [31:0] exp_q[$];         // AR addresses still expected this frame
   int unsigned beat_due_q[$];    // earliest cycle each requested beat may return
   logic [31:0] hs_addr_log[$];
   int          model_out = 0;
   bit          exp_err = 1'b0;
   int unsigned cyc = 0;
   int          hs_count = 0;
   int          beat_count = 0;
   int          done_count = 0;
   int          av_cycles = 0;
   bit          prev_wait = 1'b0;
   bit          prev_rst = 1'b1;
   bit          prev_done = 1'b0;
   logic [31:0] prev_addr = '0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: observe outputs at the falling edge, drive inputs, and model
   // what the following rising edge will do.
   task automatic cycle();
      bit hs;
      bit beat;
      bit cand;
      @(negedge clk);
      cyc++;
      if (prev_wait && !prev_rst) begin
         check("ar_hold_valid", {31'd0, M_AXI_ARVALID}, 32'd1);
         check("ar_hold_addr", M_AXI_ARADDR, prev_addr);
      end
      if (frame_done_o) begin
         done_count++;
         check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      end
      prev_done = frame_done_o;
      if (M_AXI_ARVALID) av_cycles++;

      RST         = rst_pol;
      VGA_VS      = vs_pol;
      FIFO_WR_CNT = fifo_pol;
      case (ar_mode)
         0:       M_AXI_ARREADY = 1'b0;
         1:       M_AXI_ARREADY = 1'b1;
         default: M_AXI_ARREADY = 1'($urandom_range(0, 1));
      endcase
      cand = r_en && (beat_due_q.size() > 0) && (model_out > r_floor) &&
             (beat_due_q.size() > 0 ? beat_due_q[0] <= cyc : 1'b0);
      if (force_beat) begin
         M_AXI_RVALID = 1'b1;
         M_AXI_RREADY = 1'b1;
      end else if (cand) begin
         M_AXI_RVALID = 1'b1;
         M_AXI_RREADY = r_stall_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
         M_AXI_RVALID = 1'b0;
         M_AXI_RREADY = 1'($urandom_range(0, 1));
      end
      beat = M_AXI_RVALID && M_AXI_RREADY;
      M_AXI_RRESP = (beat && err_beat_pend) ? 2'b10 : 2'b00;
      M_AXI_RLAST = 1'b0;

      hs        = M_AXI_ARVALID && M_AXI_ARREADY;
      prev_wait = M_AXI_ARVALID && !M_AXI_ARREADY;
      prev_addr = M_AXI_ARADDR;
      prev_rst  = rst_pol;
      if (rst_pol) begin
         exp_q.delete();
         beat_due_q.delete();
         model_out = 0;
         exp_err   = 1'b0;
      end else begin
         if (hs) begin
            hs_count++;
            hs_addr_log.push_back(M_AXI_ARADDR);
            if (exp_q.size() == 0) check("ar_unexpected", exp_q.size(), 32'd1);
            else check("ar_addr", M_AXI_ARADDR, exp_q.pop_front());
            check("ar_fifo_room", {31'd0, model_out <= LIMIT - BURST_LEN}, 32'd1);
            for (int i = 0; i < BURST_LEN; i++) beat_due_q.push_back(cyc + 4);
         end
         if (beat) begin
            beat_count++;
            if (!force_beat && beat_due_q.size() > 0) void'(beat_due_q.pop_front());
            if (M_AXI_RRESP != 2'b00) exp_err = 1'b1;
            if (model_out == 0 && !hs) exp_err = 1'b1;
            err_beat_pend = 1'b0;
         end
         model_out = model_out + (hs ? BURST_LEN : 0) - ((beat && (model_out > 0 || hs)) ? 1 : 0);
      end
      force_beat = 1'b0;
   endtask

   // Pull VS low briefly, load the expected address list, then raise VS on
   // the next cycle() call.
   task automatic start_frame();
      vs_pol = 1'b0;
      repeat (4) cycle();
      exp_q.delete();
      for (int i = 0; i < TOTAL; i++) exp_q.push_back(FB_BASE + 32'(64 * i));
      vs_pol = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      int n;
      d0 = done_count;
      n  = 0;
      while (done_count == d0 && n < budget) begin
         cycle();
         n++;
      end
      check(tag, done_count, d0 + 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      int h0;
      int b0;
      int av0;
      bit armed;

      repeat (3) cycle();
      rst_pol = 1'b0;
      cycle();
      check("rst_arvalid", {31'd0, M_AXI_ARVALID}, 32'd0);
      check("rst_araddr", M_AXI_ARADDR, FB_BASE);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, frame_done_o}, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      check("rst_outstanding", {21'd0, dbg_outstanding_o}, 32'd0);
      check("rst_state_idle", {30'd0, dbg_state_o}, 32'd0);
      check("arlen", {24'd0, M_AXI_ARLEN}, 32'(BURST_LEN - 1));
      check("arsize", {29'd0, M_AXI_ARSIZE}, 32'd2);
      check("arburst", {30'd0, M_AXI_ARBURST}, 32'd1);

      // Full frame, ARREADY high, beats 4 cycles after each AR.
      ar_mode = 1;
      hs_addr_log.delete();
      h0 = hs_count;
      start_frame();
      n = 0;
      do begin
         cycle();
         n++;
      end while (!M_AXI_ARVALID && n < 12);
      check("first_ar_within_4", {31'd0, (n - 1) <= 4}, 32'd1);
      check("first_araddr", M_AXI_ARADDR, FB_BASE);
      wait_done("frame_done_full", 20000);
      check("full_burst_count", hs_count - h0, TOTAL);
      check("second_araddr", hs_addr_log.size() > 1 ? hs_addr_log[1] : 32'd0, FB_BASE + 32'h40);
      check("full_all_addr_issued", exp_q.size(), 32'd0);
      check("full_busy_after_done", {31'd0, busy_o}, 32'd0);
      check("full_outstanding_zero", {21'd0, dbg_outstanding_o}, 32'(model_out));

      // FIFO nearly full holds requests off until it drains.
      fifo_pol = 10'd1000;
      start_frame();
      av0 = av_cycles;
      repeat (20) cycle();
      check("throttle_no_arvalid", av_cycles - av0, 32'd0);
      fifo_pol = 10'd900;
      cycle();
      cycle();
      check("throttle_release_arvalid", {31'd0, M_AXI_ARVALID}, 32'd1);
      fifo_pol = 10'd0;
      wait_done("frame_done_throttle", 20000);

      // ARREADY stalled 10 cycles, then simultaneous AR and R beat at outstanding 5.
      ar_mode = 0;
      r_floor = 5;
      start_frame();
      n = 0;
      do begin
         cycle();
         n++;
      end while (!M_AXI_ARVALID && n < 12);
      h0 = hs_count;
      repeat (10) cycle();
      check("stall_no_handshake", hs_count - h0, 32'd0);
      check("stall_addr", M_AXI_ARADDR, FB_BASE);
      ar_mode = 1;
      cycle();
      ar_mode = 0;
      repeat (3) cycle();
      check("stall_one_handshake", hs_count - h0, 32'd1);
      n = 0;
      while (model_out != 5 && n < 100) begin
         cycle();
         n++;
      end
      cycle();
      check("outstanding_five", {21'd0, dbg_outstanding_o}, 32'd5);
      check("waiting_in_addr", {31'd0, M_AXI_ARVALID}, 32'd1);
      ar_mode = 1;
      r_floor = 0;
      cycle();
      cycle();
      check("hs_and_beat_net", {21'd0, dbg_outstanding_o}, 32'd20);
      wait_done("frame_done_stall", 20000);

      // Abort after burst 100 with 32 beats outstanding.
      h0 = hs_count;
      start_frame();
      n = 0;
      while (hs_count - h0 < 100 && n < 5000) begin
         cycle();
         n++;
      end
      fifo_pol = 10'd1000;
      r_floor  = 32;
      n = 0;
      while (model_out != 32 && n < 3000) begin
         cycle();
         n++;
      end
      repeat (5) cycle();
      check("abort_outstanding_32", {21'd0, dbg_outstanding_o}, 32'd32);
      vs_pol = 1'b0;
      h0 = hs_count;
      b0 = beat_count;
      repeat (10) cycle();
      check("abort_busy_draining", {31'd0, busy_o}, 32'd1);
      r_floor = 0;
      wait_done("frame_done_abort", 200);
      check("abort_no_more_ar", hs_count - h0, 32'd0);
      check("abort_beats_drained", beat_count - b0, 32'd32);
      check("abort_busy_after", {31'd0, busy_o}, 32'd0);
      exp_q.delete();
      fifo_pol = 10'd0;

      // Randomized frame with one error response.
      ar_mode      = 2;
      r_stall_rand = 1'b1;
      check("err_before_inject", {31'd0, err_o}, {31'd0, exp_err});
      h0 = hs_count;
      armed = 1'b0;
      start_frame();
      n = 0;
      b0 = done_count;
      while (done_count == b0 && n < 40000) begin
         fifo_pol = 10'($urandom_range(0, 700));
         if (!armed && hs_count - h0 == 50) begin
            err_beat_pend = 1'b1;
            armed = 1'b1;
         end
         cycle();
         n++;
      end
      check("rand_frame_done", done_count, b0 + 1);
      check("rand_burst_count", hs_count - h0, TOTAL);
      check("rand_outstanding_zero", {21'd0, dbg_outstanding_o}, 32'(model_out));
      ar_mode      = 1;
      r_stall_rand = 1'b0;
      fifo_pol     = 10'd0;
      repeat (10) cycle();
      check("err_sticky", {31'd0, err_o}, {31'd0, exp_err});
      check("err_expected_set", {31'd0, exp_err}, 32'd1);
      rst_pol = 1'b1;
      repeat (2) cycle();
      rst_pol = 1'b0;
      cycle();
      check("err_cleared_by_rst", {31'd0, err_o}, {31'd0, exp_err});

      // Stray beat with nothing outstanding.
      force_beat = 1'b1;
      cycle();
      cycle();
      check("underflow_err", {31'd0, err_o}, {31'd0, exp_err});
      check("underflow_count_zero", {21'd0, dbg_outstanding_o}, 32'(model_out));

      // Reset while ARVALID is waiting.
      ar_mode = 0;
      start_frame();
      n = 0;
      do begin
         cycle();
         n++;
      end while (!M_AXI_ARVALID && n < 12);
      check("pre_rst_arvalid", {31'd0, M_AXI_ARVALID}, 32'd1);
      rst_pol = 1'b1;
      cycle();
      cycle();
      check("rst_mid_arvalid", {31'd0, M_AXI_ARVALID}, 32'd0);
      check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
      rst_pol = 1'b0;
      repeat (3) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
